pe_instr_trace_buffer: RTL and testbench
========================================

// Module: pe_instr_trace_buffer
// PURPOSE
//   Synthesizable instruction-trace capture unit that sits beside the PE fetch stage.
//   It decodes each fetched instruction into a 14-bit opcode key, key = {instr[8:0], instr[61:57]},
//   and flags keys outside the supported ISA set.
//   It records {key, sequence number} in a circular buffer around a masked-match trigger, and the buffer is drained later through a read port.
//   This replaces simulation-only opcode viewing with on-chip debug visibility.
// PARAMETERS
//   INSTR_W  128  instruction word width; must be >= 62
//   DEPTH    16   trace entries; power of 2, >= 2
//   SEQ_W    16   width of the per-instruction sequence counter
// PORTS
//   clk          in   1                      clock, rising edge
//   rstn         in   1                      asynchronous active-low reset
//   instr_valid  in   1                      instr holds a fetched instruction this cycle
//   instr        in   INSTR_W                fetched instruction word
//   arm          in   1                      single-cycle pulse: clear the trace and start capture
//   trig_key     in   14                     trigger key value
//   trig_mask    in   14                     key bits compared (1 = compare); all-zero = match any
//   post_cnt     in   $clog2(DEPTH)+1        entries captured after the trigger entry
//   state_o      out  2                      0 IDLE, 1 ARMED, 2 CAPTURE, 3 DONE
//   count        out  $clog2(DEPTH)+1        valid entries held, 0..DEPTH
//   overflow     out  1                      a post-trigger entry was dropped because the buffer was full
//   unknown_cnt  out  16                     unknown-key instructions seen since the last arm
//   rd_en        in   1                      pop the oldest entry
//   rd_valid     out  1                      rd_key/rd_seq/rd_unknown are valid
//   rd_key       out  14                     popped opcode key
//   rd_seq       out  SEQ_W                  sequence number of the popped entry
//   rd_unknown   out  1                      popped key was unknown
// BEHAVIOUR
//   Reset (rstn=0, async): all of the following are zero:
//     - state IDLE, count, wr_ptr, rd_ptr, seq, overflow, unknown_cnt
//     - rd_valid, rd_key, rd_seq, rd_unknown
//   Buffer RAM contents: not reset.
//   Known keys, as op9:funct5:
//     - 0:{0,1}
//     - 1:{0..10}
//     - 2:{0..3}
//     - 4:{0..3}
//     - 8:{0,1,2,6,7,8,9,10}
//   Any other key is unknown.
//   seq increments by 1 on every instr_valid, in every state, and wraps modulo 2^SEQ_W.
//   Each entry stores the seq value before that increment.
//   unknown_cnt increments on instr_valid with an unknown key, saturates at 16'hFFFF, and clears on arm.
//   match = instr_valid && (((key ^ trig_key) & trig_mask) == 0)
//   arm has the highest priority in any state:
//     - next state ARMED
//     - count, wr_ptr, rd_ptr, overflow and unknown_cnt cleared
//     - rd_valid=0
//     - an instr_valid in the same cycle is not recorded, but seq still increments
//   IDLE:
//     - instr_valid is not recorded
//     - reads allowed
//   ARMED (pre-trigger history):
//     - every instr_valid is written
//     - when count==DEPTH the oldest entry is overwritten: rd_ptr advances, count stays DEPTH
//     - match: the entry is written; post_cnt==0 -> DONE, else CAPTURE with remaining=post_cnt
//   CAPTURE:
//     - count<DEPTH: each instr_valid is written and remaining decrements; remaining reaching 0 -> DONE
//     - count==DEPTH: the instr_valid is dropped, overflow=1, -> DONE
//     - a further match in CAPTURE is ignored
//   DONE:
//     - no writes
//     - reads allowed
//     - stays in DONE until arm
//   Read (IDLE or DONE only), 1-cycle latency:
//     - rd_en with count>0 in cycle N: rd_valid=1 in N+1 with the oldest entry; rd_ptr advances; count decrements
//     - rd_en with count==0, or in ARMED/CAPTURE: ignored, rd_valid=0 in N+1
//     - rd_valid is a single-cycle pulse per pop
//     - rd_key/rd_seq/rd_unknown hold their last value while rd_valid=0
//   Pointers are $clog2(DEPTH) bits and wrap naturally.
//   count = number of entries, 0..DEPTH.
//   Reset mid-capture aborts immediately to IDLE with an empty buffer.
// TESTING
//   - Reset, then 5 cycles idle -> state_o=0, count=0, rd_valid=0, unknown_cnt=0.
//   - Arm, mask=0, post_cnt=3, feed ADD (key 14'h020), SUB (14'h021), MUL (14'h022), MADD (14'h040)
//     -> DONE after the 4th instruction, count=4, pops return keys 020,021,022,040 with seq 0..3.
//   - DEPTH=16, arm, trig_key=14'h100 (ADDI), mask=14'h3FFF, 20 non-matching instructions then ADDI, post_cnt=0
//     -> count=16, first pop is the 6th instruction's key (seq 5), last pop is 14'h100.
//   - Arm, match on the 10th instruction, post_cnt=16, keep feeding
//     -> 6 post-trigger entries fill the buffer, the 7th is dropped, overflow=1, count=16, state DONE.
//   - Feed key 14'h3FF (unknown) 3 times plus NOP
//     -> unknown_cnt=3, popped entries carry rd_unknown=1,1,1,0.
//   - Assert arm together with instr_valid while in DONE with count=5
//     -> count=0 next cycle, state ARMED, seq still advances.
//   - rd_en with count==0 -> rd_valid stays 0, rd_key unchanged.

Source files
------------

// File: rtl/pe_instr_trace_buffer.sv
// Instruction-trace capture unit: decodes fetched instructions into opcode keys and records
// {key, seq} in a circular buffer around a masked-match trigger, drained via a read port.
module pe_instr_trace_buffer #(
  parameter int unsigned INSTR_W = 128,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned SEQ_W   = 16,
  localparam int unsigned PW     = $clog2(DEPTH),
  localparam int unsigned CW     = PW + 1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               instr_valid,
  input  logic [INSTR_W-1:0] instr,
  input  logic               arm,
  input  logic [13:0]        trig_key,
  input  logic [13:0]        trig_mask,
  input  logic [CW-1:0]      post_cnt,
  output logic [1:0]         state_o,
  output logic [CW-1:0]      count,
  output logic               overflow,
  output logic [15:0]        unknown_cnt,
  input  logic               rd_en,
  output logic               rd_valid,
  output logic [13:0]        rd_key,
  output logic [SEQ_W-1:0]   rd_seq,
  output logic               rd_unknown
);

  localparam int unsigned EW = 1 + 14 + SEQ_W;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StArmed   = 2'd1,
    StCapture = 2'd2,
    StDone    = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     count_q;
  logic [CW-1:0]     remaining_q;
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [SEQ_W-1:0]  seq_q;
  logic              overflow_q;
  logic [15:0]       unknown_cnt_q;
  logic              rd_valid_q;
  logic [13:0]       rd_key_q;
  logic [SEQ_W-1:0]  rd_seq_q;
  logic              rd_unknown_q;
  logic [EW-1:0]     mem_q [DEPTH];

  logic [13:0] key;
  logic [15:0] funct_mask;
  logic        key_known;
  logic        match;
  logic        full;
  logic        wr_en, pop, drop, overwrite;
  logic [EW-1:0] rd_entry;

  // Only the opcode fields are decoded; the rest of the word is ignored.
  logic unused_instr;
  assign unused_instr = ^instr;

  assign key = {instr[8:0], instr[61:57]};

  // Per-op9 bitmap of supported funct5 values (all supported funct5 are < 16).
  always_comb begin
    funct_mask = '0;
    case (key[13:5])
      9'd0:       funct_mask = 16'h0003;
      9'd1:       funct_mask = 16'h07FF;
      9'd2, 9'd4: funct_mask = 16'h000F;
      9'd8:       funct_mask = 16'h07C7;
      default:    funct_mask = '0;
    endcase
    key_known = ~key[4] & funct_mask[key[3:0]];
  end

  assign match = instr_valid && (((key ^ trig_key) & trig_mask) == 14'd0);
  assign full  = (count_q == CW'(DEPTH));

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (arm) begin
      state_d = StArmed;
    end else begin
      case (state_q)
        StArmed: begin
          if (match) state_d = (post_cnt == '0) ? StDone : StCapture;
        end
        StCapture: begin
          if (instr_valid && (full || remaining_q == CW'(1))) state_d = StDone;
        end
        default: ;
      endcase
    end
  end

  // Output / control decode
  always_comb begin
    wr_en   = 1'b0;
    pop     = 1'b0;
    drop    = 1'b0;
    state_o = state_q;
    if (!arm) begin
      case (state_q)
        StIdle, StDone: pop = rd_en && (count_q != '0);
        StArmed:        wr_en = instr_valid;
        StCapture: begin
          wr_en = instr_valid && !full;
          drop  = instr_valid && full;
        end
        default: ;
      endcase
    end
  end

  // Writing into a full buffer only happens while ARMED: the oldest entry is discarded.
  assign overwrite = wr_en && full;
  assign rd_entry  = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q       <= '0;
      remaining_q   <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      seq_q         <= '0;
      overflow_q    <= 1'b0;
      unknown_cnt_q <= '0;
      rd_valid_q    <= 1'b0;
      rd_key_q      <= '0;
      rd_seq_q      <= '0;
      rd_unknown_q  <= 1'b0;
    end else begin
      if (instr_valid) seq_q <= seq_q + SEQ_W'(1);
      if (arm) begin
        count_q       <= '0;
        wr_ptr_q      <= '0;
        rd_ptr_q      <= '0;
        overflow_q    <= 1'b0;
        unknown_cnt_q <= '0;
        rd_valid_q    <= 1'b0;
      end else begin
        if (wr_en) wr_ptr_q <= wr_ptr_q + PW'(1);
        if (pop || overwrite) rd_ptr_q <= rd_ptr_q + PW'(1);
        if (wr_en && !full) begin
          count_q <= count_q + CW'(1);
        end else if (pop) begin
          count_q <= count_q - CW'(1);
        end
        if (drop) overflow_q <= 1'b1;
        if (state_q == StArmed && match) begin
          remaining_q <= post_cnt;
        end else if (state_q == StCapture && wr_en) begin
          remaining_q <= remaining_q - CW'(1);
        end
        if (instr_valid && !key_known && unknown_cnt_q != 16'hFFFF) begin
          unknown_cnt_q <= unknown_cnt_q + 16'd1;
        end
        rd_valid_q <= pop;
        if (pop) begin
          rd_unknown_q <= rd_entry[EW-1];
          rd_key_q     <= rd_entry[EW-2 -: 14];
          rd_seq_q     <= rd_entry[SEQ_W-1:0];
        end
      end
    end
  end

  // Trace RAM, intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= {~key_known, key, seq_q};
  end

  assign count       = count_q;
  assign overflow    = overflow_q;
  assign unknown_cnt = unknown_cnt_q;
  assign rd_valid    = rd_valid_q;
  assign rd_key      = rd_key_q;
  assign rd_seq      = rd_seq_q;
  assign rd_unknown  = rd_unknown_q;

endmodule

// File: tb/tb_pe_instr_trace_buffer.sv
// Bench for pe_instr_trace_buffer: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_pe_instr_trace_buffer;

  localparam int INSTR_W = 128;
  localparam int DEPTH   = 16;
  localparam int SEQ_W   = 16;
  localparam int CW      = 5;

  logic               clk = 1'b0;
  logic               rstn;
  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic               arm;
  logic [13:0]        trig_key;
  logic [13:0]        trig_mask;
  logic [CW-1:0]      post_cnt;
  logic [1:0]         state_o;
  logic [CW-1:0]      count;
  logic               overflow;
  logic [15:0]        unknown_cnt;
  logic               rd_en;
  logic               rd_valid;
  logic [13:0]        rd_key;
  logic [SEQ_W-1:0]   rd_seq;
  logic               rd_unknown;

  always #5 clk = ~clk;

  pe_instr_trace_buffer #(
    .INSTR_W(INSTR_W),
    .DEPTH  (DEPTH),
    .SEQ_W  (SEQ_W)
  ) u_dut (
    .clk        (clk),
    .rstn       (rstn),
    .instr_valid(instr_valid),
    .instr      (instr),
    .arm        (arm),
    .trig_key   (trig_key),
    .trig_mask  (trig_mask),
    .post_cnt   (post_cnt),
    .state_o    (state_o),
    .count      (count),
    .overflow   (overflow),
    .unknown_cnt(unknown_cnt),
    .rd_en      (rd_en),
    .rd_valid   (rd_valid),
    .rd_key     (rd_key),
    .rd_seq     (rd_seq),
    .rd_unknown (rd_unknown)
  );

  typedef struct {
    logic [13:0] key;
    int          seq;
    bit          unk;
  } ent_t;

  ent_t        m_q[$];
  int          m_state, m_rem, m_unk, m_seq, m_rseq;
  bit          m_ovf, m_rv, m_runk;
  logic [13:0] m_rkey;

  int compared   = 0;
  int mismatched = 0;

  function automatic logic [13:0] key_of(logic [INSTR_W-1:0] w);
    return {w[8:0], w[61:57]};
  endfunction

  function automatic bit is_known(logic [13:0] k);
    int op = int'(k[13:5]);
    int f  = int'(k[4:0]);
    case (op)
      0:       return f <= 1;
      1:       return f <= 10;
      2, 4:    return f <= 3;
      8:       return f inside {0, 1, 2, 6, 7, 8, 9, 10};
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [INSTR_W-1:0] mk(logic [13:0] k);
    logic [INSTR_W-1:0] w;
    w = {$urandom, $urandom, $urandom, $urandom};
    w[8:0]   = k[13:5];
    w[61:57] = k[4:0];
    return w;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_state = 0; m_rem = 0; m_unk = 0; m_seq = 0;
    m_ovf = 0; m_rv = 0; m_runk = 0; m_rkey = '0; m_rseq = 0;
  endtask

  task automatic model_step();
    logic [13:0] k;
    bit          m, u, rv;
    ent_t        e;
    k  = key_of(instr);
    m  = instr_valid && (((k ^ trig_key) & trig_mask) == 14'd0);
    u  = !is_known(k);
    rv = 0;
    e.key = k; e.seq = m_seq; e.unk = u;
    if (arm) begin
      m_q.delete(); m_state = 1; m_ovf = 0; m_unk = 0;
    end else begin
      case (m_state)
        0, 3: if (rd_en && m_q.size() > 0) begin
          ent_t p;
          p = m_q.pop_front();
          m_rkey = p.key; m_rseq = p.seq; m_runk = p.unk; rv = 1;
        end
        1: if (instr_valid) begin
          m_q.push_back(e);
          if (m_q.size() > DEPTH) void'(m_q.pop_front());
          if (m) begin
            if (post_cnt == 0) m_state = 3;
            else begin m_state = 2; m_rem = int'(post_cnt); end
          end
        end
        2: if (instr_valid) begin
          if (m_q.size() < DEPTH) begin
            m_q.push_back(e);
            m_rem--;
            if (m_rem == 0) m_state = 3;
          end else begin
            m_ovf = 1; m_state = 3;
          end
        end
        default: ;
      endcase
      if (instr_valid && u && m_unk < 65535) m_unk++;
    end
    m_rv = rv;
    if (instr_valid) m_seq = (m_seq + 1) % 65536;
  endtask

  task automatic compare();
    chk("state", 64'(state_o), 64'(m_state));
    chk("count", 64'(count), 64'(m_q.size()));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("unknown_cnt", 64'(unknown_cnt), 64'(m_unk));
    chk("rd_valid", 64'(rd_valid), 64'(m_rv));
    chk("rd_key", 64'(rd_key), 64'(m_rkey));
    chk("rd_seq", 64'(rd_seq), 64'(m_rseq));
    chk("rd_unknown", 64'(rd_unknown), 64'(m_runk));
  endtask

  task automatic step();
    @(posedge clk);
    if (rstn) model_step();
    else model_reset();
    @(negedge clk);
    compare();
  endtask

  task automatic idle();
    instr_valid = 0; arm = 0; rd_en = 0; instr = '0;
  endtask

  task automatic feed(logic [13:0] k);
    instr_valid = 1; instr = mk(k);
    step();
    instr_valid = 0;
  endtask

  task automatic pop1();
    rd_en = 1;
    step();
    rd_en = 0;
  endtask

  task automatic do_arm(logic [13:0] tk, logic [13:0] tm, int pc);
    trig_key = tk; trig_mask = tm; post_cnt = CW'(pc);
    arm = 1;
    step();
    arm = 0;
  endtask

  // Asserted mid low-phase so the asynchronous clear is observed before any clock edge.
  task automatic do_reset();
    idle();
    #2;
    rstn = 0;
    #1;
    chk("async_rst_state", 64'(state_o), 64'd0);
    chk("async_rst_count", 64'(count), 64'd0);
    chk("async_rst_rd_valid", 64'(rd_valid), 64'd0);
    model_reset();
    step();
    step();
    rstn = 1;
  endtask

  logic [13:0] exp2 [4];
  logic [13:0] k;

  initial begin
    exp2[0] = 14'h020; exp2[1] = 14'h021; exp2[2] = 14'h022; exp2[3] = 14'h040;
    idle();
    trig_key = '0; trig_mask = '0; post_cnt = '0;
    rstn = 1;
    model_reset();

    // Reset then idle
    do_reset();
    repeat (5) step();
    chk("idle_state", 64'(state_o), 64'd0);
    chk("idle_count", 64'(count), 64'd0);
    chk("idle_rd_valid", 64'(rd_valid), 64'd0);
    chk("idle_unknown", 64'(unknown_cnt), 64'd0);

    // Match-any trigger with three post entries
    do_arm(14'h000, 14'h0000, 3);
    for (int i = 0; i < 4; i++) feed(exp2[i]);
    chk("t2_state", 64'(state_o), 64'd3);
    chk("t2_count", 64'(count), 64'd4);
    for (int i = 0; i < 4; i++) begin
      pop1();
      chk("t2_pop_valid", 64'(rd_valid), 64'd1);
      chk("t2_pop_key", 64'(rd_key), 64'(exp2[i]));
      chk("t2_pop_seq", 64'(rd_seq), 64'(i));
    end

    // Pre-trigger history wraps, keeping the last 16 entries
    do_reset();
    do_arm(14'h100, 14'h3FFF, 0);
    for (int i = 0; i < 20; i++) begin
      k = 14'h020 + 14'(i % 11);
      feed(k);
    end
    feed(14'h100);
    chk("t3_state", 64'(state_o), 64'd3);
    chk("t3_count", 64'(count), 64'd16);
    pop1();
    chk("t3_first_key", 64'(rd_key), 64'h025);
    chk("t3_first_seq", 64'(rd_seq), 64'd5);
    repeat (15) pop1();
    chk("t3_last_key", 64'(rd_key), 64'h100);
    chk("t3_last_seq", 64'(rd_seq), 64'd20);
    chk("t3_empty", 64'(count), 64'd0);

    // Post-trigger overflow
    do_reset();
    do_arm(14'h041, 14'h3FFF, 16);
    repeat (9) feed(14'h020);
    feed(14'h041);
    chk("t4_capture", 64'(state_o), 64'd2);
    repeat (6) feed(14'h020);
    chk("t4_full_count", 64'(count), 64'd16);
    chk("t4_full_ovf", 64'(overflow), 64'd0);
    chk("t4_full_state", 64'(state_o), 64'd2);
    feed(14'h020);
    chk("t4_ovf", 64'(overflow), 64'd1);
    chk("t4_done", 64'(state_o), 64'd3);
    repeat (3) feed(14'h020);
    chk("t4_count", 64'(count), 64'd16);

    // Unknown keys
    do_reset();
    do_arm(14'h001, 14'h3FFF, 0);
    repeat (3) feed(14'h3FF);
    feed(14'h000);
    feed(14'h001);
    chk("t5_unknown_cnt", 64'(unknown_cnt), 64'd3);
    chk("t5_count", 64'(count), 64'd5);
    for (int i = 0; i < 4; i++) begin
      pop1();
      chk("t5_rd_unknown", 64'(rd_unknown), (i < 3) ? 64'd1 : 64'd0);
    end

    // Arm together with instr_valid while DONE
    do_reset();
    do_arm(14'h000, 14'h0000, 4);
    repeat (5) feed(14'h020);
    chk("t6_count5", 64'(count), 64'd5);
    arm = 1; instr_valid = 1; instr = mk(14'h020);
    step();
    idle();
    chk("t6_rearm_count", 64'(count), 64'd0);
    chk("t6_rearm_state", 64'(state_o), 64'd1);
    post_cnt = '0;
    feed(14'h021);
    pop1();
    chk("t6_seq_advanced", 64'(rd_seq), 64'd6);

    // Read from an empty buffer
    pop1();
    chk("t7_no_valid", 64'(rd_valid), 64'd0);
    chk("t7_key_held", 64'(rd_key), 64'h021);

    // Reset in the middle of capture
    do_arm(14'h000, 14'h0000, 10);
    repeat (3) feed(14'h022);
    chk("t8_capture", 64'(state_o), 64'd2);
    do_reset();
    step();
    chk("t8_after_count", 64'(count), 64'd0);

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        arm = ($urandom_range(0, 99) < 3);
        if (arm) begin
          case ($urandom_range(0, 2))
            0:       trig_mask = 14'h0000;
            1:       trig_mask = 14'h3FFF;
            default: trig_mask = 14'($urandom);
          endcase
          trig_key = {9'($urandom_range(0, 8)), 5'($urandom_range(0, 15))};
          post_cnt = CW'($urandom_range(0, 16));
        end
        instr_valid = ($urandom_range(0, 99) < 70);
        if ($urandom_range(0, 3) == 0) begin
          k = 14'($urandom);
        end else begin
          case ($urandom_range(0, 5))
            0: k[13:5] = 9'd0;
            1: k[13:5] = 9'd1;
            2: k[13:5] = 9'd2;
            3: k[13:5] = 9'd4;
            4: k[13:5] = 9'd8;
            default: k[13:5] = 9'd31;
          endcase
          k[4:0] = 5'($urandom_range(0, 15));
        end
        instr = mk(k);
        rd_en = $urandom_range(0, 1);
        step();
      end
    end
    idle();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
